// File: rtl/detection_pkg.sv
// rtl/detection_pkg.sv - shared channel state, counter sizing and default parameters for the echo detector
package detection_pkg;

  typedef enum logic [1:0] {IDLE, QUAL, FIRED, RELEASE} ch_state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_DEBOUNCE = 4;
  localparam int DEF_REARM    = 8;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_TIMEOUT  = 50000;

  // One counter serves both the debounce and re-arm phases, so size it for the larger.
  function automatic int cnt_width(input int debounce, input int rearm);
    int m;
    m = (debounce > rearm) ? debounce : rearm;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/detect_channel.sv
// rtl/detect_channel.sv - one debounce/re-arm FSM; fire is the combinational next value of the channel pulse
module detect_channel
  import detection_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  parameter int REARM    = DEF_REARM
) (
  input  logic gclk,
  input  logic rst,
  input  logic detect_en,
  input  logic echo,
  output logic fire
);

  localparam int CW = cnt_width(DEBOUNCE, REARM);
  localparam logic [CW-1:0] DEB_C   = CW'(DEBOUNCE);
  localparam logic [CW-1:0] REARM_C = CW'(REARM);

  ch_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fire    = 1'b0;
    cnt_inc = cnt + CW'(1);
    if (!detect_en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (echo) begin
            if (DEBOUNCE == 1) begin
              state_n = FIRED;
              fire    = 1'b1;
            end else begin
              state_n = QUAL;
              cnt_n   = CW'(1);
            end
          end
        end
        QUAL: begin
          if (!echo) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt_inc == DEB_C) begin
            state_n = FIRED;
            cnt_n   = '0;
            fire    = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        FIRED: begin
          if (!echo) begin
            if (REARM == 1) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              state_n = RELEASE;
              cnt_n   = CW'(1);
            end
          end
        end
        RELEASE: begin
          // Echo returning before the re-arm time means the same object: no new pulse.
          if (echo) begin
            state_n = FIRED;
            cnt_n   = '0;
          end else if (cnt_inc == REARM_C) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_detection.sv
// rtl/multi_detection.sv - N-channel debounced echo detector with combined pulse, index and event counter
// Optional DETECT_TIMEOUT_EN adds a no-detection timeout pulse; otherwise timeout is tied low.
module multi_detection
  import detection_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  parameter int REARM    = DEF_REARM,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  localparam int FW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic             gclk,
  input  logic             rst,
  input  logic             detect_en,
  input  logic [N-1:0]     echo_in,
  input  logic             event_clr,
  output logic [N-1:0]     detected,
  output logic             detected_any,
  output logic [FW-1:0]    first_ch,
  output logic [CNT_W-1:0] event_cnt,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]  fire;
  logic [FW-1:0] first_n;

  for (genvar i = 0; i < N; i++) begin : g_ch
    detect_channel #(
      .DEBOUNCE (DEBOUNCE),
      .REARM    (REARM)
    ) u_ch (
      .gclk      (gclk),
      .rst       (rst),
      .detect_en (detect_en),
      .echo      (echo_in[i]),
      .fire      (fire[i])
    );
  end

  // Descending scan so the lowest firing channel is the last to write.
  always_comb begin
    first_n = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (fire[i]) first_n = FW'(i);
    end
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      detected     <= '0;
      detected_any <= 1'b0;
      first_ch     <= '0;
    end else begin
      detected     <= fire;
      detected_any <= |fire;
      first_ch     <= first_n;
    end
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      event_cnt <= '0;
    end else if (event_clr) begin
      event_cnt <= detected_any ? CNT_W'(1) : '0;
    end else if (detected_any && (event_cnt != CNT_MAX)) begin
      event_cnt <= event_cnt + CNT_W'(1);
    end
  end

`ifdef DETECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] to_cnt;

  // A registered fire clears the counter first, so a coinciding terminal count is lost.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (!detect_en || detected_any) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (to_cnt == TO_LAST) begin
      to_cnt  <= '0;
      timeout <= 1'b1;
    end else begin
      to_cnt  <= to_cnt + TW'(1);
      timeout <= 1'b0;
    end
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT > 0);
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_multi_detection.sv
// tb/tb_multi_detection.sv - segment table plus run-length reference model scoreboard for multi_detection
module tb_multi_detection;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int RA  = 8;
  localparam int CW  = 16;
  localparam int TO  = 100;

  logic        gclk = 1'b0;
  logic        rst;
  logic        detect_en;
  logic [3:0]  echo_in;
  logic        event_clr;
  logic [3:0]  detected;
  logic        detected_any;
  logic [1:0]  first_ch;
  logic [15:0] event_cnt;
  logic        timeout;

  multi_detection #(
    .N        (N),
    .DEBOUNCE (DEB),
    .REARM    (RA),
    .CNT_W    (CW),
    .TIMEOUT  (TO)
  ) dut (
    .gclk         (gclk),
    .rst          (rst),
    .detect_en    (detect_en),
    .echo_in      (echo_in),
    .event_clr    (event_clr),
    .detected     (detected),
    .detected_any (detected_any),
    .first_ch     (first_ch),
    .event_cnt    (event_cnt),
    .timeout      (timeout)
  );

  always #5 gclk = ~gclk;

  typedef struct packed {
    logic [3:0]  det;
    logic        any;
    logic [1:0]  first;
    logic [15:0] cnt;
    logic        to;
  } obs_t;

  typedef struct {
    logic       en;
    logic [3:0] echo;
    logic       clr;
    int         len;
    int         exp_pulses;
    int         exp_cnt;
  } seg_t;

  obs_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   pulses;

  // Reference model: per channel either armed (counting a high run) or disarmed (counting a low run).
  bit   armed[4];
  int   run[4];
  int   low[4];
  obs_t m;
  int   to_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      armed[i] = 1'b1;
      run[i]   = 0;
      low[i]   = 0;
    end
    m      = '0;
    to_cnt = 0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] echo, input logic clr);
    obs_t nx;
    nx = '0;
    for (int i = 0; i < 4; i++) begin
      if (!en) begin
        armed[i] = 1'b1;
        run[i]   = 0;
        low[i]   = 0;
      end else if (armed[i]) begin
        if (echo[i]) begin
          run[i]++;
          if (run[i] >= DEB) begin
            nx.det[i] = 1'b1;
            armed[i]  = 1'b0;
            run[i]    = 0;
            low[i]    = 0;
          end
        end else begin
          run[i] = 0;
        end
      end else begin
        if (!echo[i]) begin
          low[i]++;
          if (low[i] >= RA) begin
            armed[i] = 1'b1;
            low[i]   = 0;
          end
        end else begin
          low[i] = 0;
        end
      end
    end
    nx.any = |nx.det;
    for (int i = 3; i >= 0; i--) if (nx.det[i]) nx.first = 2'(i);
    if (clr)                           nx.cnt = m.any ? 16'd1 : 16'd0;
    else if (m.any && m.cnt != 16'hFFFF) nx.cnt = m.cnt + 16'd1;
    else                               nx.cnt = m.cnt;
`ifdef DETECT_TIMEOUT_EN
    if (!en || m.any) begin
      to_cnt = 0;
    end else if (to_cnt == TO - 1) begin
      nx.to  = 1'b1;
      to_cnt = 0;
    end else begin
      to_cnt++;
    end
`endif
    m = nx;
    sb.push_back(nx);
  endtask

  task automatic step(input logic en, input logic [3:0] echo, input logic clr);
    obs_t got, exp;
    detect_en = en;
    echo_in   = echo;
    event_clr = clr;
    model_step(en, echo, clr);
    @(posedge gclk);
    #1;
    got = {detected, detected_any, first_ch, event_cnt, timeout};
    check("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check($sformatf("cycle_%0t", $time), 64'(got), 64'(exp));
    end
    if (detected_any) pulses++;
  endtask

  task automatic apply_reset(input string name);
    rst = 1'b1;
    #2;
    check(name, 64'({detected, detected_any, first_ch, event_cnt, timeout}), 64'd0);
    model_reset();
    sb.delete();
    @(posedge gclk);
    #1;
    rst = 1'b0;
  endtask

  task automatic refire_latency(input string name);
    int  lat;
    bit  found;
    lat   = 0;
    found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      step(1'b1, 4'b0100, 1'b0);
      if (detected == 4'b0100) begin
        found = 1'b1;
        lat   = k;
      end
    end
    check(name, 64'(lat), 64'(DEB));
  endtask

  seg_t segs[20];

  initial begin
    segs[0]  = '{1'b1, 4'b0000, 1'b0,  3, 0, 0};
    segs[1]  = '{1'b1, 4'b0100, 1'b0, 10, 1, 1};
    segs[2]  = '{1'b1, 4'b0000, 1'b0,  8, 0, 1};
    segs[3]  = '{1'b1, 4'b0001, 1'b0,  3, 0, 1};
    segs[4]  = '{1'b1, 4'b0000, 1'b0,  2, 0, 1};
    segs[5]  = '{1'b1, 4'b0001, 1'b0,  5, 1, 2};
    segs[6]  = '{1'b1, 4'b0000, 1'b0,  5, 0, 2};
    segs[7]  = '{1'b1, 4'b0001, 1'b0,  6, 0, 2};
    segs[8]  = '{1'b1, 4'b0000, 1'b0,  8, 0, 2};
    segs[9]  = '{1'b1, 4'b0001, 1'b0,  5, 1, 3};
    segs[10] = '{1'b1, 4'b0000, 1'b0,  8, 0, 3};
    segs[11] = '{1'b1, 4'b1010, 1'b0,  5, 1, 4};
    segs[12] = '{1'b1, 4'b0000, 1'b0,  8, 0, 4};
    segs[13] = '{1'b1, 4'b1010, 1'b0,  4, 1, 4};
    segs[14] = '{1'b1, 4'b1010, 1'b1,  1, 0, 1};
    segs[15] = '{1'b1, 4'b0000, 1'b0,  8, 0, 1};
    segs[16] = '{1'b1, 4'b0000, 1'b1,  1, 0, 0};
    segs[17] = '{1'b1, 4'b0100, 1'b0,  3, 0, 0};
    segs[18] = '{1'b0, 4'b0100, 1'b0,  2, 0, 0};
    segs[19] = '{1'b1, 4'b0100, 1'b0,  5, 1, 1};

    rst       = 1'b1;
    detect_en = 1'b0;
    echo_in   = 4'b0000;
    event_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge gclk);
    #1;
    apply_reset("reset_state");

    for (int s = 0; s < 20; s++) begin
      pulses = 0;
      for (int c = 0; c < segs[s].len; c++) step(segs[s].en, segs[s].echo, segs[s].clr);
      check($sformatf("seg%0d_pulses", s), 64'(pulses), 64'(segs[s].exp_pulses));
      check($sformatf("seg%0d_event_cnt", s), 64'(event_cnt), 64'(segs[s].exp_cnt));
    end

    // Channel 2 is now FIRED with its echo still high.
    step(1'b1, 4'b0100, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    apply_reset("reset_mid_fired");
    refire_latency("refire_after_reset");
    apply_reset("reset_mid_pulse");
    refire_latency("refire_after_pulse_reset");
    for (int c = 0; c < 10; c++) step(1'b1, 4'b0000, 1'b0);

`ifdef DETECT_TIMEOUT_EN
    apply_reset("reset_before_timeout");
    pulses = 0;
    for (int c = 0; c < 205; c++) begin
      step(1'b1, 4'b0000, 1'b0);
      if (timeout) pulses++;
    end
    check("timeout_pulses", 64'(pulses), 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/multi_detection.md
# multi_detection

Parametrised successor to the single-channel object detector. It takes N synchronised ultrasonic comparator outputs and debounces each channel independently. For every qualified object it emits exactly one single-cycle `detected` pulse, then re-arms only after the echo has been absent for a programmable time. It sits between the comparator synchronisers and the ranging/control FSM, and also provides a combined pulse, a lowest-channel index and a saturating event counter.

## Interface
- `N`, default 4: channel count, 1..16.
- `DEBOUNCE`, default 4: consecutive qualifying samples required to fire, ≥1.
- `REARM`, default 8: consecutive low samples required to re-arm after a fire, ≥1.
- `CNT_W`, default 16: event counter width.
- `TIMEOUT`, default 50000: no-detection timeout in cycles, ≥2. Used only with `DETECT_TIMEOUT_EN`.
- `gclk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `detect_en` in 1: detection window; low forces every channel to IDLE.
- `echo_in` in N: synchronised comparator outputs, bit i is channel i.
- `event_clr` in 1: synchronous clear of `event_cnt`.
- `detected` out N: one-cycle pulse per channel per qualified object.
- `detected_any` out 1: OR of `detected`, same cycle.
- `first_ch` out $clog2(N) (min 1): index of the lowest set bit of `detected`; 0 when none.
- `event_cnt` out CNT_W: saturating count of cycles with `detected_any`=1.
- `timeout` out 1: one-cycle no-detection pulse; constant 0 without the macro.

## Operation
- Reset: all channels IDLE, counters 0, and `detected`, `detected_any`, `first_ch`, `event_cnt`, `timeout` all 0.
- Per channel, qualifier q = `detect_en` & `echo_in[i]`. Per-channel counter width is $clog2(max(DEBOUNCE,REARM)+1).
- IDLE: if q, go to QUAL with cnt=1. If DEBOUNCE=1, go directly to FIRED instead and pulse.
- QUAL: if q, cnt+1. When cnt reaches DEBOUNCE, go to FIRED and pulse `detected[i]`. If !q, go to IDLE with cnt=0, and there is no pulse.
- FIRED: if `echo_in[i]`=0, go to RELEASE with cnt=1 (REARM=1 goes directly to IDLE). While high, stay; there is never a second pulse.
- RELEASE: if low, cnt+1, and at REARM go to IDLE. If high before REARM, return to FIRED with no pulse.
- `detect_en`=0 in any state forces IDLE and cnt=0 on the next edge. A pulse already registered is still delivered.
- Channels are fully independent; simultaneous fires on several channels are all reported in the same cycle.
- `event_cnt`: +1 per cycle with `detected_any`=1, and it holds at 2^CNT_W−1. When `event_clr` and `detected_any` are both 1 in the same cycle, `event_cnt` loads 1; `event_clr` alone loads 0.

## Timing
- `detected[i]` is registered. It is high for exactly the one cycle following the edge at which the DEBOUNCE-th consecutive q was sampled.
- Latency from the first qualifying sample edge to the pulse is DEBOUNCE cycles.
- `detected_any` and `first_ch` are registered and aligned with `detected`.
- `event_cnt` updates one cycle after the corresponding `detected_any`.
- Reset may assert mid-QUAL, mid-FIRED or mid-pulse. Outputs clear immediately (asynchronously). After release, a still-high echo requires a full DEBOUNCE to fire again.
- No handshake: the downstream block must sample `detected` every cycle.

## Configuration
- `DETECT_TIMEOUT_EN` defined: a timeout counter runs while `detect_en`=1.
  - It clears on `detected_any`, on `detect_en`=0, and on reset.
  - When it reaches TIMEOUT, `timeout` pulses for one cycle and the counter restarts at 0.
  - If a fire and the terminal count coincide, the fire wins and there is no timeout.
- `DETECT_TIMEOUT_EN` undefined: no counter logic; `timeout` is tied 0 and the port remains.

## Structure
- Package `detection_pkg`: channel state enum (IDLE, QUAL, FIRED, RELEASE), the cnt-width helper function, and the default parameter constants.
- Sub-module `detect_channel`: one FSM plus counter, instantiated N times in a generate loop. The top holds the OR, the priority encoder, the event counter and the timeout.

## Test plan
- N=4, DEBOUNCE=4: `echo_in[2]` high for 10 cycles with en=1 → `detected`=4'b0100 for exactly one cycle, 4 cycles after first sample; `first_ch`=2; `event_cnt`=1.
- Glitch: `echo_in[0]` high for 3 cycles then low → no pulse. Then high for 4 cycles → one pulse.
- Re-arm, REARM=8: fire, drop low for 5 cycles, high again → no pulse. Then low for 8 cycles, high for 4 → second pulse, `event_cnt`=2.
- Simultaneous: channels 1 and 3 qualify on the same edge → `detected`=4'b1010, `first_ch`=1, `event_cnt` increments by 1. Repeat together with `event_clr` → `event_cnt`=1.
- `detect_en` dropped at cnt=3, then `rst` pulsed mid-FIRED → outputs 0 at once, no pulse. A held echo refires after DEBOUNCE once en returns.
- `DETECT_TIMEOUT_EN`, TIMEOUT=100: en high with no echo → `timeout` pulses at cycles 100 and 200. A detection at cycle 150 postpones the next pulse to cycle 250.
